pulse_scheduler: RTL
====================

Name: pulse_scheduler

Overview:
Sequencer that drains the pulse-instruction FIFO and plays each pulse at its scheduled time.
- Owns a timebase counter and pops one entry at a time from pulse_register.
- Holds the popped entry until the timebase equals its tstart.
- Drives phase/amp/freq to the NCO/DAC front-end for tlen cycles.
- Sits between pulse_register and the waveform generator; started and aborted by the core's CSR logic.

Parameters:
TIME_W, 32, timebase counter width; must be >= `PULSE_REG_TSTART_W
LATE_CNT_W, 16, late-pulse counter width (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle request to begin the sequence; ignored while busy
abort  in  1  synchronous stop; returns to IDLE from any state
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when the sequence ends because the FIFO is empty
late_err  out  1  sticky; set when a pulse starts after its tstart; cleared by start or rst
timebase  out  TIME_W  cycles since start was accepted
fifo_rd_en  out  1  pop request to pulse_register
fifo_empty  in  1  pulse_register empty flag
fifo_rd_phase/amp/freq/tstart/tlen  in  `PULSE_REG_*_W  registered FIFO read data, valid 1 cycle after fifo_rd_en
out_valid  out  1  pulse active
out_phase  out  `PULSE_REG_PHASE_W  current pulse phase
out_amp  out  `PULSE_REG_AMP_W  current pulse amplitude
out_freq  out  `PULSE_REG_FREQ_W  current pulse frequency

Behaviour:
- Reset: every output is 0; state IDLE; staging registers cleared.
- States: IDLE, FETCH, WAIT_DATA, WAIT_START, PLAY.
- IDLE:
  - start is accepted only in IDLE.
  - On acceptance: timebase <= 0, late_err <= 0, next state FETCH.
- Timebase: increments by 1 every cycle while busy, wraps modulo 2^TIME_W, holds its value in IDLE.
- FETCH:
  - fifo_empty=1: done=1 for one cycle, then IDLE.
  - Otherwise: fifo_rd_en=1 for exactly one cycle, then WAIT_DATA.
  - fifo_rd_en is never high outside FETCH.
- WAIT_DATA: latch all five fifo_rd_* fields into staging, then WAIT_START.
- WAIT_START (tstart zero-extended to TIME_W):
  - tlen==0: discard the entry, go to FETCH; no output.
  - tstart == timebase+1: go to PLAY, so the first out_valid cycle has timebase == tstart.
  - tstart <= timebase: set late_err, go to PLAY next cycle.
  - Otherwise: stay in WAIT_START.
- PLAY:
  - out_valid=1; out_* come from staging and are stable for all tlen cycles.
  - A down-counter is loaded with tlen. After the last cycle: out_valid=0, go to FETCH.
- Outside PLAY: out_valid=0 and out_* are 0.
- Minimum gap: 3 cycles (FETCH, WAIT_DATA, WAIT_START) from the end of one pulse to the start of the next. A tstart inside that gap is played late and sets late_err.
- abort:
  - Highest priority over all other transitions.
  - Next cycle: state IDLE, out_valid=0, fifo_rd_en=0.
  - The FIFO is not flushed. An entry already popped in WAIT_DATA or later is lost.
- start and abort in the same cycle: abort wins; stays IDLE.
- rst asserted mid-pulse: out_valid=0 on the following edge, exactly as at reset.

Optional Feature:
PULSE_SCHED_LATE_CNT_EN
- Defined:
  - Adds output late_cnt [LATE_CNT_W-1:0].
  - Increments on each late pulse, saturates at all-ones.
  - Cleared by rst or an accepted start.
- Undefined: no port, no counter logic; late_err behaviour is unchanged.

Decomposition:
- Shared package pulse_sched_pkg:
  - state enum sched_state_e.
  - Struct pulse_t {phase, amp, freq, tstart, tlen} sized by the `PULSE_REG_*_W macros.
  - Localparam MIN_GAP = 3.
- One sub-module, pulse_timebase: TIME_W counter with clear, enable and wrap; exposes count and count+1.

Test Plan:
1. FIFO holds {tstart=10, tlen=4, amp=0x55}; pulse start -> out_valid high for timebase 10..13, out_amp=0x55, then done 1 cycle after the FETCH that sees empty.
2. Two entries {tstart=5, tlen=3} and {tstart=9, tlen=2} -> first pulse at 5..7; second is inside the 3-cycle gap, so it plays at 11..12 and late_err=1 (late_cnt=1 with the feature).
3. Entry with tlen=0 followed by {tstart=20, tlen=1} -> no output for the first entry; single out_valid cycle at timebase=20; late_err=0.
4. abort asserted at the 2nd PLAY cycle of a tlen=8 pulse -> out_valid=0 next cycle; busy=0; remaining FIFO entries untouched (fifo_empty stays 0).
5. start pulsed while busy, and start+abort in the same cycle in IDLE -> both ignored; timebase is not cleared in the first case, stays IDLE in the second.
6. rst asserted during WAIT_START -> all outputs 0 next cycle; a subsequent start replays the remaining FIFO entries correctly.

Source files
------------

// File: rtl/pulse_sched_pkg.sv
// Shared types for the pulse scheduler: state encoding and staged pulse entry.
// Field widths follow the PULSE_REG_*_W macros; defaults apply when pulse_register is absent.
`ifndef PULSE_REG_PHASE_W
`define PULSE_REG_PHASE_W 16
`endif
`ifndef PULSE_REG_AMP_W
`define PULSE_REG_AMP_W 16
`endif
`ifndef PULSE_REG_FREQ_W
`define PULSE_REG_FREQ_W 32
`endif
`ifndef PULSE_REG_TSTART_W
`define PULSE_REG_TSTART_W 32
`endif
`ifndef PULSE_REG_TLEN_W
`define PULSE_REG_TLEN_W 16
`endif

package pulse_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_DATA,
        S_WAIT_START,
        S_PLAY
    } sched_state_e;

    typedef logic [`PULSE_REG_TLEN_W-1:0] tlen_t;

    typedef struct packed {
        logic [`PULSE_REG_PHASE_W-1:0]  phase;
        logic [`PULSE_REG_AMP_W-1:0]    amp;
        logic [`PULSE_REG_FREQ_W-1:0]   freq;
        logic [`PULSE_REG_TSTART_W-1:0] tstart;
        tlen_t                          tlen;
    } pulse_t;

    // FETCH + WAIT_DATA + WAIT_START between consecutive pulses
    localparam int MIN_GAP = 3;

endpackage

// File: rtl/pulse_timebase.sv
// Free-running timebase for the scheduler: clear wins over enable, wraps naturally.
// Exposes both the current count and count+1 for the on-time start compare.
module pulse_timebase #(
    parameter int TIME_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    output logic [TIME_W-1:0] count,
    output logic [TIME_W-1:0] count_next
);

    assign count_next = count + TIME_W'(1);

    // count register: cleared on accepted start, advances while enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/pulse_scheduler.sv
// Pulse sequencer: pops pulse_register entries and plays each at its tstart for tlen cycles.
// Optional PULSE_SCHED_LATE_CNT_EN adds a saturating late-pulse counter output late_cnt.
module pulse_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int TIME_W     = 32,
    parameter int LATE_CNT_W = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    output logic                           busy,
    output logic                           done,
    output logic                           late_err,
    output logic [TIME_W-1:0]              timebase,
    output logic                           fifo_rd_en,
    input  logic                           fifo_empty,
    input  logic [`PULSE_REG_PHASE_W-1:0]  fifo_rd_phase,
    input  logic [`PULSE_REG_AMP_W-1:0]    fifo_rd_amp,
    input  logic [`PULSE_REG_FREQ_W-1:0]   fifo_rd_freq,
    input  logic [`PULSE_REG_TSTART_W-1:0] fifo_rd_tstart,
    input  logic [`PULSE_REG_TLEN_W-1:0]   fifo_rd_tlen,
    output logic                           out_valid,
`ifdef PULSE_SCHED_LATE_CNT_EN
    output logic [LATE_CNT_W-1:0]          late_cnt,
`endif
    output logic [`PULSE_REG_PHASE_W-1:0]  out_phase,
    output logic [`PULSE_REG_AMP_W-1:0]    out_amp,
    output logic [`PULSE_REG_FREQ_W-1:0]   out_freq
);

    if (TIME_W < `PULSE_REG_TSTART_W || LATE_CNT_W < 1) begin : g_param_check
        $error("pulse_scheduler: TIME_W narrower than tstart or bad LATE_CNT_W");
    end

    sched_state_e      state;
    sched_state_e      state_d;
    pulse_t            stage;
    tlen_t             remain;
    logic [TIME_W-1:0] timebase_next;
    logic [TIME_W-1:0] tstart_ext;
    logic              accept;
    logic              play_go;
    logic              late_hit;

    assign accept     = (state == S_IDLE) && start && !abort;
    assign busy       = (state != S_IDLE);
    assign tstart_ext = TIME_W'(stage.tstart);

    pulse_timebase #(
        .TIME_W(TIME_W)
    ) u_timebase (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .en        (busy),
        .count     (timebase),
        .count_next(timebase_next)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // next state, FIFO pop and play/late decisions; abort overrides everything
    always_comb begin
        state_d    = state;
        fifo_rd_en = 1'b0;
        play_go    = 1'b0;
        late_hit   = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (fifo_empty) begin
                        state_d = S_IDLE;
                    end else begin
                        fifo_rd_en = 1'b1;
                        state_d    = S_WAIT_DATA;
                    end
                end
                S_WAIT_DATA: begin
                    state_d = S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (stage.tlen == '0) begin
                        state_d = S_FETCH;
                    end else if (tstart_ext == timebase_next) begin
                        play_go = 1'b1;
                        state_d = S_PLAY;
                    end else if (tstart_ext <= timebase) begin
                        play_go  = 1'b1;
                        late_hit = 1'b1;
                        state_d  = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (remain == tlen_t'(1)) state_d = S_FETCH;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // staging register and pulse length down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            stage  <= '0;
            remain <= '0;
        end else begin
            if (state == S_WAIT_DATA) begin
                stage <= '{phase:  fifo_rd_phase,
                           amp:    fifo_rd_amp,
                           freq:   fifo_rd_freq,
                           tstart: fifo_rd_tstart,
                           tlen:   fifo_rd_tlen};
            end
            if (play_go) begin
                remain <= stage.tlen;
            end else if (state == S_PLAY) begin
                remain <= remain - tlen_t'(1);
            end
        end
    end

    // done pulse after an empty FETCH; sticky late flag cleared on accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            done     <= 1'b0;
            late_err <= 1'b0;
        end else begin
            done <= (state == S_FETCH) && fifo_empty && !abort;
            if (accept) begin
                late_err <= 1'b0;
            end else if (late_hit) begin
                late_err <= 1'b1;
            end
        end
    end

`ifdef PULSE_SCHED_LATE_CNT_EN
    // saturating count of pulses that started after their tstart
    always_ff @(posedge clk) begin
        if (rst) begin
            late_cnt <= '0;
        end else if (accept) begin
            late_cnt <= '0;
        end else if (late_hit && late_cnt != '1) begin
            late_cnt <= late_cnt + LATE_CNT_W'(1);
        end
    end
`endif

    assign out_valid = (state == S_PLAY);
    assign out_phase = out_valid ? stage.phase : '0;
    assign out_amp   = out_valid ? stage.amp   : '0;
    assign out_freq  = out_valid ? stage.freq  : '0;

endmodule
